// File: rtl/uart_lbs_pkg.sv
// rtl/uart_lbs_pkg.sv - register map, bit indices and reset constants for uart_lbs_regs
package uart_lbs_pkg;

  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_RX_CNT  = 3'd2;
  localparam logic [2:0] REG_TX_CNT  = 3'd3;
  localparam logic [2:0] REG_IRQ_EN  = 3'd4;
  localparam logic [2:0] REG_RX_THR  = 3'd5;
  localparam logic [2:0] REG_CTRL    = 3'd6;
  localparam logic [2:0] REG_SCRATCH = 3'd7;

  localparam int ST_RX_NEMPTY = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_TX_EMPTY  = 2;
  localparam int ST_RX_OVF    = 3;
  localparam int ST_RX_FERR   = 4;
  localparam int ST_TX_OVF    = 5;

  localparam int CTRL_TX_FLUSH = 0;
  localparam int CTRL_RX_FLUSH = 1;
  localparam int CTRL_LOOPBACK = 2;

  localparam int IRQ_RX_THR   = 0;
  localparam int IRQ_TX_EMPTY = 1;
  localparam int IRQ_ERR      = 2;

  localparam logic [7:0] STATUS_RST = 8'h04;
  localparam logic [7:0] RX_THR_RST = 8'h01;

  // A threshold of 0 would make the RX interrupt fire on an empty FIFO; treat it as 1.
  function automatic logic [7:0] eff_thr(input logic [7:0] thr);
    return (thr == 8'h00) ? 8'h01 : thr;
  endfunction

endpackage

// File: rtl/lbs_sync_fifo.sv
// rtl/lbs_sync_fifo.sv - show-ahead synchronous byte FIFO with count, full, empty and flush
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           empties the FIFO on the next edge; overrides push/pop
//   push, wdata     write request and byte; ignored when full unless a pop happens too
//   pop             read request; ignored when empty
//   rdata           head byte (0x00 when empty)
//   count           occupancy 0..2^AW
//   full, empty     occupancy flags
module lbs_sync_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_pop;
  logic          do_push;

  assign empty   = (cnt == '0);
  assign full    = cnt[AW];
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to 0x00 while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? 8'h00 : mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/uart_lbs_regs.sv
// rtl/uart_lbs_regs.sv - per-channel UART register file with TX/RX FIFOs, sticky status and irq
// Optional feature macro: UART_LBS_LOOPBACK_EN (CTRL.b2 routes TX FIFO into RX FIFO).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   lbs_addr/din/dout          register offset, write byte, combinational read byte
//   lbs_we, lbs_re, lbs_cs_n   write/read strobes qualified by active-low channel select
//   tx_data, tx_valid, tx_ready  TX FIFO head toward the serializer
//   rx_data, rx_valid, rx_frame_err  received byte strobe from the deserializer
//   irq                        registered level interrupt
module uart_lbs_regs
  import uart_lbs_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int U_DLY   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] lbs_addr,
  input  logic [7:0] lbs_din,
  output logic [7:0] lbs_dout,
  input  logic       lbs_we,
  input  logic       lbs_re,
  input  logic       lbs_cs_n,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_frame_err,
  output logic       irq
);

  // U_DLY is kept for drop-in compatibility with older instantiations; updates here are zero-delay.
  if (U_DLY < 0) begin : g_neg_dly
  end

  logic       wr_en, rd_en;
  logic [7:0] irq_en, rx_thr, scratch;
  logic       rx_ovf, rx_ferr, tx_ovf;
  logic       lb_en;

  logic       tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic [FIFO_AW:0] tx_count;
  logic       rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [7:0] rx_head, rx_wdata;
  logic [FIFO_AW:0] rx_count;
  logic [7:0] rx_cnt8, tx_cnt8;
  logic       rx_ovf_set, rx_ferr_set, tx_ovf_set;
  logic [7:0] w1c;
  logic       irq_next;

  assign wr_en = lbs_we && !lbs_cs_n;
  assign rd_en = lbs_re && !lbs_cs_n;

  assign tx_push  = wr_en && (lbs_addr == REG_DATA);
  assign tx_flush = wr_en && (lbs_addr == REG_CTRL) && lbs_din[CTRL_TX_FLUSH];
  assign rx_flush = wr_en && (lbs_addr == REG_CTRL) && lbs_din[CTRL_RX_FLUSH];
  assign rx_pop   = rd_en && (lbs_addr == REG_DATA) && !rx_empty;
  assign w1c      = (wr_en && (lbs_addr == REG_STATUS)) ? lbs_din : 8'h00;

`ifdef UART_LBS_LOOPBACK_EN
  logic lb_move;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lb_en <= 1'b0;
    else if (wr_en && (lbs_addr == REG_CTRL))
      lb_en <= lbs_din[CTRL_LOOPBACK];
  end

  // In loopback the serializer and deserializer are cut off: one byte per cycle
  // moves TX head to RX tail while there is room.
  assign lb_move     = lb_en && !tx_empty && !rx_full;
  assign tx_pop      = lb_en ? lb_move : (!tx_empty && tx_ready);
  assign rx_push     = lb_en ? lb_move : rx_valid;
  assign rx_wdata    = lb_en ? tx_head : rx_data;
  assign rx_ferr_set = !lb_en && rx_valid && rx_frame_err;
  assign tx_valid    = !tx_empty && !lb_en;
`else
  assign lb_en       = 1'b0;
  assign tx_pop      = !tx_empty && tx_ready;
  assign rx_push     = rx_valid;
  assign rx_wdata    = rx_data;
  assign rx_ferr_set = rx_valid && rx_frame_err;
  assign tx_valid    = !tx_empty;
`endif

  assign tx_data = tx_head;

  // Overflow means the byte was really dropped: a same-cycle pop makes room, a flush discards anyway.
  assign tx_ovf_set = tx_push && tx_full && !tx_pop && !tx_flush;
  assign rx_ovf_set = rx_push && rx_full && !rx_pop && !rx_flush;

  lbs_sync_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (tx_flush),
    .push  (tx_push),
    .wdata (lbs_din),
    .pop   (tx_pop),
    .rdata (tx_head),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  lbs_sync_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (rx_flush),
    .push  (rx_push),
    .wdata (rx_wdata),
    .pop   (rx_pop),
    .rdata (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign rx_cnt8 = 8'(rx_count);
  assign tx_cnt8 = 8'(tx_count);

  // Sticky flags: a set in the same cycle wins over write-1-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ovf  <= STATUS_RST[ST_RX_OVF];
      rx_ferr <= STATUS_RST[ST_RX_FERR];
      tx_ovf  <= STATUS_RST[ST_TX_OVF];
    end else begin
      rx_ovf  <= (rx_ovf  && !w1c[ST_RX_OVF])  || rx_ovf_set;
      rx_ferr <= (rx_ferr && !w1c[ST_RX_FERR]) || rx_ferr_set;
      tx_ovf  <= (tx_ovf  && !w1c[ST_TX_OVF])  || tx_ovf_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en  <= 8'h00;
      rx_thr  <= RX_THR_RST;
      scratch <= 8'h00;
    end else if (wr_en) begin
      case (lbs_addr)
        REG_IRQ_EN:  irq_en  <= {5'b0, lbs_din[2:0]};
        REG_RX_THR:  rx_thr  <= lbs_din;
        REG_SCRATCH: scratch <= lbs_din;
        default:     ;
      endcase
    end
  end

  assign irq_next = (irq_en[IRQ_RX_THR]   && (rx_cnt8 >= eff_thr(rx_thr))) ||
                    (irq_en[IRQ_TX_EMPTY] && tx_empty) ||
                    (irq_en[IRQ_ERR]      && (rx_ovf || rx_ferr || tx_ovf));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= irq_next;
  end

  always_comb begin
    lbs_dout = 8'h00;
    case (lbs_addr)
      REG_DATA:    lbs_dout = rx_head;
      REG_STATUS: begin
        lbs_dout[ST_RX_NEMPTY] = !rx_empty;
        lbs_dout[ST_TX_FULL]   = tx_full;
        lbs_dout[ST_TX_EMPTY]  = tx_empty;
        lbs_dout[ST_RX_OVF]    = rx_ovf;
        lbs_dout[ST_RX_FERR]   = rx_ferr;
        lbs_dout[ST_TX_OVF]    = tx_ovf;
      end
      REG_RX_CNT:  lbs_dout = rx_cnt8;
      REG_TX_CNT:  lbs_dout = tx_cnt8;
      REG_IRQ_EN:  lbs_dout = irq_en;
      REG_RX_THR:  lbs_dout = rx_thr;
      REG_CTRL:    lbs_dout[CTRL_LOOPBACK] = lb_en;
      REG_SCRATCH: lbs_dout = scratch;
      default:     lbs_dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_lbs_regs.sv
// tb/tb_uart_lbs_regs.sv - directed self-checking bench for uart_lbs_regs
module tb_uart_lbs_regs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] lbs_addr;
  logic [7:0] lbs_din;
  logic [7:0] lbs_dout;
  logic       lbs_we, lbs_re, lbs_cs_n;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err;
  logic       irq;

  int n_assert = 0;
  int n_fail   = 0;

  uart_lbs_regs #(.FIFO_AW(4), .U_DLY(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lbs_addr     (lbs_addr),
    .lbs_din      (lbs_din),
    .lbs_dout     (lbs_dout),
    .lbs_we       (lbs_we),
    .lbs_re       (lbs_re),
    .lbs_cs_n     (lbs_cs_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic peek(input logic [2:0] a, input string tag, input logic [7:0] exp);
    lbs_addr = a;
    #1;
    chk(tag, lbs_dout, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic csn = 1'b0);
    @(negedge clk);
    lbs_addr = a; lbs_din = d; lbs_cs_n = csn; lbs_we = 1'b1;
    @(negedge clk);
    lbs_we = 1'b0; lbs_cs_n = 1'b0;
  endtask

  task automatic rd_pop(input string tag, input logic [7:0] exp);
    @(negedge clk);
    lbs_addr = 3'd0;
    #1;
    chk(tag, lbs_dout, exp);
    lbs_re = 1'b1;
    @(negedge clk);
    lbs_re = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] d, input logic ferr);
    @(negedge clk);
    rx_data = d; rx_valid = 1'b1; rx_frame_err = ferr;
    @(negedge clk);
    rx_valid = 1'b0; rx_frame_err = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; lbs_addr = 3'd0; lbs_din = 8'h00; lbs_we = 1'b0; lbs_re = 1'b0;
    lbs_cs_n = 1'b0; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_frame_err = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    peek(3'd1, "rst_status", 8'h04);
    rst_n = 1'b1;
    peek(3'd5, "rst_rx_thr", 8'h01);
    peek(3'd4, "rst_irq_en", 8'h00);
    peek(3'd7, "rst_scratch", 8'h00);
    peek(3'd0, "rst_data_empty", 8'h00);

    // TX show-ahead
    wr(3'd0, 8'hA5);
    wr(3'd0, 8'h3C);
    peek(3'd3, "tx_cnt_2", 8'h02);
    chk("tx_valid_1", {7'b0, tx_valid}, 8'h01);
    chk("tx_head_a5", tx_data, 8'hA5);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("tx_head_3c", tx_data, 8'h3C);
    @(negedge clk);
    tx_ready = 1'b0;
    chk("tx_valid_0", {7'b0, tx_valid}, 8'h00);
    peek(3'd3, "tx_cnt_0", 8'h00);
    peek(3'd1, "tx_status_end", 8'h04);

    // fill TX, then overfill RX
    for (int i = 0; i < 16; i++) wr(3'd0, 8'h50 + 8'(i));
    peek(3'd1, "tx_full_status", 8'h02);
    for (int i = 0; i < 17; i++) rx_push(8'(i), 1'b0);
    peek(3'd2, "rx_cnt_16", 8'h10);
    peek(3'd1, "rx_ovf_status", 8'h0B);
    wr(3'd0, 8'hEE);
    peek(3'd1, "tx_ovf_status", 8'h2B);
    peek(3'd3, "tx_cnt_after_ovf", 8'h10);
    chk("tx_head_kept", tx_data, 8'h50);
    for (int i = 0; i < 16; i++) rd_pop($sformatf("rx_pop_%0d", i), 8'(i));
    peek(3'd2, "rx_cnt_drained", 8'h00);
    peek(3'd0, "rx_data_empty", 8'h00);
    peek(3'd1, "status_sticky", 8'h2A);

    // full RX with simultaneous push and pop
    wr(3'd1, 8'h28);
    peek(3'd1, "status_w1c", 8'h02);
    for (int i = 0; i < 16; i++) rx_push(8'h20 + 8'(i), 1'b0);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h77; lbs_addr = 3'd0; lbs_re = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; lbs_re = 1'b0;
    peek(3'd2, "rx_cnt_pushpop", 8'h10);
    peek(3'd1, "no_ovf_pushpop", 8'h03);
    peek(3'd0, "rx_head_after_pop", 8'h21);
    wr(3'd6, 8'h02);
    peek(3'd2, "rx_flush_cnt", 8'h00);

    // TX flush
    wr(3'd6, 8'h01);
    peek(3'd3, "tx_flush_full", 8'h00);
    for (int i = 0; i < 5; i++) wr(3'd0, 8'h90 + 8'(i));
    peek(3'd3, "tx_cnt_5", 8'h05);
    wr(3'd6, 8'h01);
    chk("tx_valid_flush", {7'b0, tx_valid}, 8'h00);
    peek(3'd3, "tx_cnt_flush", 8'h00);
    peek(3'd6, "ctrl_read0", 8'h00);
    peek(3'd1, "status_idle", 8'h04);

    // RX threshold interrupt
    wr(3'd4, 8'h01);
    wr(3'd5, 8'h03);
    peek(3'd5, "rx_thr_3", 8'h03);
    rx_push(8'h60, 1'b0);
    rx_push(8'h61, 1'b0);
    rx_push(8'h62, 1'b0);
    chk("irq_lag", {7'b0, irq}, 8'h00);
    @(negedge clk);
    chk("irq_rise", {7'b0, irq}, 8'h01);
    rd_pop("irq_pop_data", 8'h60);
    chk("irq_hold", {7'b0, irq}, 8'h01);
    @(negedge clk);
    chk("irq_fall", {7'b0, irq}, 8'h00);
    wr(3'd5, 8'h00);
    @(negedge clk);
    chk("irq_thr0", {7'b0, irq}, 8'h01);
    wr(3'd4, 8'h00);
    @(negedge clk);
    chk("irq_disabled", {7'b0, irq}, 8'h00);
    wr(3'd6, 8'h02);

    // framing error sticky and set-beats-clear
    rx_push(8'h44, 1'b1);
    peek(3'd1, "ferr_set", 8'h15);
    wr(3'd1, 8'h10);
    peek(3'd1, "ferr_clear", 8'h05);
    @(negedge clk);
    rx_valid = 1'b1; rx_frame_err = 1'b1; rx_data = 8'h45;
    lbs_addr = 3'd1; lbs_din = 8'h10; lbs_we = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_frame_err = 1'b0; lbs_we = 1'b0;
    peek(3'd1, "ferr_set_wins", 8'h15);
    peek(3'd2, "ferr_bytes_kept", 8'h02);

    // scratch, chip select gating, loopback bit absent by default
    wr(3'd7, 8'h5A);
    peek(3'd7, "scratch_rw", 8'h5A);
    wr(3'd7, 8'hFF, 1'b1);
    peek(3'd7, "scratch_cs_gate", 8'h5A);
`ifndef UART_LBS_LOOPBACK_EN
    wr(3'd6, 8'h04);
    peek(3'd6, "ctrl_lb_absent", 8'h00);
`endif

    // reset mid-transfer
    wr(3'd0, 8'hC1);
    wr(3'd0, 8'hC2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("midrst_tx_data", tx_data, 8'h00);
    peek(3'd2, "midrst_rx_cnt", 8'h00);
    peek(3'd3, "midrst_tx_cnt", 8'h00);
    peek(3'd1, "midrst_status", 8'h04);
    peek(3'd7, "midrst_scratch", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_irq", {7'b0, irq}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
